// File: rtl/cam_cfg_sequencer.sv
// cam_cfg_sequencer: walks a {register, value} configuration table and drives
// the SCCB controller with one 3-phase write per entry. It handles ACK-error
// retries, millisecond delay entries (reg 8'hF0) and the end marker 16'hFFFF.
//
// Optional build macro CAM_CFG_READBACK_EN: after each write, read the
// register back and compare it against the written value. A mismatch uses the
// same retry budget as an ACK error.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   start_i        rising edge starts a run (ignored while busy)
//   data_pulse_i   mid-SCCB-cycle pulse shared with the controller
//   tbl_addr_o     table read address; tbl_data_i is valid one cycle later
//   sccb_*         controller handshake: addr/data/rw/start out, done/ack_err/rdata in
//   busy_o         run in progress
//   done_o         run completed; sticky until the next start
//   error_o        run aborted; sticky until the next start
//   err_addr_o     table index of the failing entry
module cam_cfg_sequencer #(
    parameter logic [7:0]  DEV_ID     = 8'h42,
    parameter int unsigned CLK_PER_MS = 50000,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              data_pulse_i,
    output logic [ADDR_W-1:0] tbl_addr_o,
    input  logic [15:0]       tbl_data_i,
    output logic [7:0]        sccb_addr_o,
    output logic [15:0]       sccb_data_o,
    output logic              sccb_rw_o,
    output logic              sccb_start_o,
    input  logic              sccb_done_i,
    input  logic              sccb_ack_err_i,
    input  logic [7:0]        sccb_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W-1:0] err_addr_o
);

    // Delay counter holds up to 255 * CLK_PER_MS without overflow.
    localparam int unsigned DLY_W = 8 + $clog2(CLK_PER_MS);
    localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_GAP,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_FAIL
`ifdef CAM_CFG_READBACK_EN
        ,
        S_RDISSUE,
        S_RDGAP
`endif
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_start_q;
    logic [ADDR_W-1:0]   r_tbl_addr, w_tbl_addr_nxt;
    logic [15:0]         r_sccb_data, w_sccb_data_nxt;
    logic                r_rw, w_rw_nxt;
    logic                r_sccb_start, w_sccb_start_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_error, w_error_nxt;
    logic [ADDR_W-1:0]   r_err_addr, w_err_addr_nxt;
    logic [RTY_W-1:0]    r_retry, w_retry_nxt;
    logic [DLY_W-1:0]    r_dly, w_dly_nxt;
    logic                r_pulse, w_pulse_nxt;     // first gap pulse seen
    logic                r_pend_next, w_pend_nxt;  // 1: advance after gap, 0: re-issue write

    logic                w_start_edge;
    logic                w_retry_ok;
    logic [DLY_W-1:0]    w_dly_load;

    assign w_start_edge = start_i & ~r_start_q;
    assign w_retry_ok   = (r_retry < RTY_W'(MAX_RETRY));
    assign w_dly_load   = DLY_W'(tbl_data_i[7:0]) * DLY_W'(CLK_PER_MS);

`ifdef CAM_CFG_READBACK_EN
    logic w_rd_ok;
    assign w_rd_ok = ~sccb_ack_err_i && (sccb_rdata_i == r_sccb_data[7:0]);
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^sccb_rdata_i;
`endif

    assign tbl_addr_o   = r_tbl_addr;
    assign sccb_addr_o  = DEV_ID;
    assign sccb_data_o  = r_sccb_data;
    assign sccb_rw_o    = r_rw;
    assign sccb_start_o = r_sccb_start;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign error_o      = r_error;
    assign err_addr_o   = r_err_addr;

    // State and registered outputs; async reset drops sccb_start_o at once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= S_IDLE;
            r_start_q    <= 1'b0;
            r_tbl_addr   <= '0;
            r_sccb_data  <= '0;
            r_rw         <= 1'b1;
            r_sccb_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_addr   <= '0;
            r_retry      <= '0;
            r_dly        <= '0;
            r_pulse      <= 1'b0;
            r_pend_next  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_start_q    <= start_i;
            r_tbl_addr   <= w_tbl_addr_nxt;
            r_sccb_data  <= w_sccb_data_nxt;
            r_rw         <= w_rw_nxt;
            r_sccb_start <= w_sccb_start_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_error      <= w_error_nxt;
            r_err_addr   <= w_err_addr_nxt;
            r_retry      <= w_retry_nxt;
            r_dly        <= w_dly_nxt;
            r_pulse      <= w_pulse_nxt;
            r_pend_next  <= w_pend_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_tbl_addr_nxt   = r_tbl_addr;
        w_sccb_data_nxt  = r_sccb_data;
        w_rw_nxt         = r_rw;
        w_sccb_start_nxt = r_sccb_start;
        w_busy_nxt       = r_busy;
        w_done_nxt       = r_done;
        w_error_nxt      = r_error;
        w_err_addr_nxt   = r_err_addr;
        w_retry_nxt      = r_retry;
        w_dly_nxt        = r_dly;
        w_pulse_nxt      = r_pulse;
        w_pend_nxt       = r_pend_next;

        case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                w_sccb_start_nxt = 1'b0;
                if (w_start_edge) begin
                    w_done_nxt     = 1'b0;
                    w_error_nxt    = 1'b0;
                    w_tbl_addr_nxt = '0;
                    w_retry_nxt    = '0;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = S_FETCH;
                end
            end

            // One cycle for the table read latency.
            S_FETCH: w_state_nxt = S_DECODE;

            S_DECODE: begin
                if (tbl_data_i == 16'hFFFF) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_DONE;
                end else if (tbl_data_i[15:8] == 8'hF0) begin
                    w_dly_nxt   = w_dly_load;
                    w_state_nxt = (tbl_data_i[7:0] == 8'h00) ? S_NEXT : S_DELAY;
                end else begin
                    w_sccb_data_nxt  = tbl_data_i;
                    w_rw_nxt         = 1'b1;
                    w_sccb_start_nxt = 1'b1;
                    w_retry_nxt      = '0;
                    w_state_nxt      = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (sccb_done_i) begin
                    w_sccb_start_nxt = 1'b0;
                    w_pulse_nxt      = 1'b0;
                    if (!sccb_ack_err_i) begin
`ifndef CAM_CFG_READBACK_EN
                        w_retry_nxt = '0;
`endif
                        w_pend_nxt  = 1'b1;
                        w_state_nxt = S_GAP;
                    end else if (w_retry_ok) begin
                        w_retry_nxt = r_retry + RTY_W'(1);
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_err_addr_nxt = r_tbl_addr;
                        w_error_nxt    = 1'b1;
                        w_busy_nxt     = 1'b0;
                        w_state_nxt    = S_FAIL;
                    end
                end
            end

            // Keep start low for two data pulses so the controller is back in its idle state.
            S_GAP: begin
                if (data_pulse_i) begin
                    w_pulse_nxt = ~r_pulse;
                    if (r_pulse) begin
                        if (r_pend_next) begin
`ifdef CAM_CFG_READBACK_EN
                            w_rw_nxt         = 1'b0;
                            w_sccb_start_nxt = 1'b1;
                            w_state_nxt      = S_RDISSUE;
`else
                            w_state_nxt = S_NEXT;
`endif
                        end else begin
                            w_rw_nxt         = 1'b1;
                            w_sccb_start_nxt = 1'b1;
                            w_state_nxt      = S_ISSUE;
                        end
                    end
                end
            end

`ifdef CAM_CFG_READBACK_EN
            S_RDISSUE: begin
                if (sccb_done_i) begin
                    w_sccb_start_nxt = 1'b0;
                    w_pulse_nxt      = 1'b0;
                    if (w_rd_ok) begin
                        w_retry_nxt = '0;
                        w_pend_nxt  = 1'b1;
                        w_state_nxt = S_RDGAP;
                    end else if (w_retry_ok) begin
                        w_retry_nxt = r_retry + RTY_W'(1);
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = S_RDGAP;
                    end else begin
                        w_err_addr_nxt = r_tbl_addr;
                        w_error_nxt    = 1'b1;
                        w_busy_nxt     = 1'b0;
                        w_state_nxt    = S_FAIL;
                    end
                end
            end

            S_RDGAP: begin
                if (data_pulse_i) begin
                    w_pulse_nxt = ~r_pulse;
                    if (r_pulse) begin
                        if (r_pend_next) begin
                            w_state_nxt = S_NEXT;
                        end else begin
                            w_rw_nxt         = 1'b1;
                            w_sccb_start_nxt = 1'b1;
                            w_state_nxt      = S_ISSUE;
                        end
                    end
                end
            end
`endif

            S_DELAY: begin
                w_dly_nxt = r_dly - DLY_W'(1);
                if (r_dly == DLY_W'(1)) begin
                    w_state_nxt = S_NEXT;
                end
            end

            // Ending on the last table slot finishes the run rather than wrapping.
            S_NEXT: begin
                if (r_tbl_addr == '1) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_tbl_addr_nxt = r_tbl_addr + ADDR_W'(1);
                    w_state_nxt    = S_FETCH;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
